// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC3 types and default widths for the pipeline stages.
package lc3_pkg;
  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;
  typedef enum logic [1:0] {
    MEM_RD   = 2'd0,
    MEM_IND  = 2'd1,
    MEM_WR   = 2'd2,
    MEM_NONE = 2'd3
  } mem_state_t;
  typedef enum logic [3:0] {
    OP_BR, OP_ADD, OP_LD, OP_ST, OP_JSR, OP_AND, OP_LDR, OP_STR,
    OP_RTI, OP_NOT, OP_LDI, OP_STI, OP_JMP, OP_RES, OP_LEA, OP_TRAP
  } op_t;
endpackage

// File: rtl/lc3_mem_watchdog.sv
// lc3_mem_watchdog: counts stalled request cycles; expired on the LIMIT-th one.
module lc3_mem_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || i_clr) ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
  assign o_expired = i_en && r_cnt == W'(LIMIT - 1);
endmodule

// File: rtl/lc3_memaccess.sv
// lc3_memaccess: LC3 memory-access stage with req/ack data-memory handshake and LDI/STI pointer phases.
// Optional LC3_MEMACCESS_TIMEOUT_EN adds a wait-cycle abort and the sticky mem_err output.
module lc3_memaccess
  import lc3_pkg::*;
#(
  parameter int ADDR_W      = LC3_ADDR_W,
  parameter int DATA_W      = LC3_DATA_W,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mem_state,
  input  logic [ADDR_W-1:0] M_addr,
  input  logic [DATA_W-1:0] M_data,
  input  logic [DATA_W-1:0] DMem_dout,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] DMem_addr,
  output logic [DATA_W-1:0] DMem_din,
  output logic              DMem_rd,
  output logic [DATA_W-1:0] memout,
  output logic              complete_data,
  output logic              busy
`ifdef LC3_MEMACCESS_TIMEOUT_EN
  ,
  output logic              mem_err
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_IND_WAIT, S_DONE} state_t;
  state_t            r_state, w_next;
  mem_state_t        w_ms;
  logic              r_ind, r_rd, w_to, w_go_idle, w_go_ind;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din, r_memout, r_ptr;
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end
  assign w_ms = mem_state_t'(mem_state);
`ifdef LC3_MEMACCESS_TIMEOUT_EN
  logic r_err;
  lc3_mem_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state != S_ACCESS),
    .i_en      (r_state == S_ACCESS && !dmem_ack),
    .o_expired (w_to)
  );
  assign mem_err = r_err;
  always_ff @(posedge clk)
    r_err <= rst ? 1'b0 : (r_err | w_to);
`else
  assign w_to = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     w_next = (start && w_ms != MEM_NONE) ? S_ACCESS : S_IDLE;
      S_ACCESS:   w_next = (dmem_ack || w_to) ? S_DONE : S_ACCESS;
      S_DONE:     w_next = r_ind ? S_IND_WAIT : S_IDLE;
      S_IND_WAIT: w_next = (w_ms == MEM_RD || w_ms == MEM_WR) ? S_ACCESS : S_IDLE;
    endcase
  end
  assign w_go_idle = r_state == S_IDLE && w_next == S_ACCESS;
  assign w_go_ind  = r_state == S_IND_WAIT && w_next == S_ACCESS;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ind    <= 1'b0;
      r_rd     <= 1'b1;
      r_addr   <= '0;
      r_din    <= '0;
      r_memout <= '0;
      r_ptr    <= '0;
    end else begin
      r_state <= w_next;
      if (w_go_idle) begin
        r_addr <= M_addr;
        r_din  <= M_data;
        r_rd   <= w_ms != MEM_WR;
        r_ind  <= w_ms == MEM_IND;
      end
      if (w_go_ind) begin
        r_addr <= r_ptr;
        r_din  <= M_data;
        r_rd   <= w_ms == MEM_RD;
      end
      if (r_state == S_ACCESS && dmem_ack) begin
        if (r_ind) r_ptr <= DMem_dout;
        else if (r_rd) r_memout <= DMem_dout;
      end
      // A timed-out read returns zero and abandons any pending indirect phase.
      if (w_to) begin
        r_ind <= 1'b0;
        if (r_rd) r_memout <= '0;
      end
      if (r_state == S_DONE) r_ind <= 1'b0;
    end
  end
  assign dmem_req      = r_state == S_ACCESS;
  assign complete_data = r_state == S_DONE;
  assign busy          = r_state != S_IDLE;
  assign DMem_addr     = r_addr;
  assign DMem_din      = r_din;
  assign DMem_rd       = r_rd;
  assign memout        = r_memout;
endmodule
